// File: rtl/mesh_router_if.sv
// mesh_router_if: link bundle for one mesh_router tile.
//
// Five links, named by the direction a flit travels on them:
//   we = east, ew = west, ns = north, sn = south, pe = local processing element.
// Per link X:
//   Xsi / Xdi : inbound valid / flit        (upstream -> router)
//   Xri       : inbound buffer ready        (router -> upstream)
//   Xso / Xdo : outbound valid / flit       (router -> downstream)
//   Xro       : downstream ready            (downstream -> router)
//
// Modports:
//   master : the router side (drives ri, so, do)
//   slave  : the neighbour / environment side (drives si, di, ro)
interface mesh_router_if #(
  parameter int DW = 64
);
  logic          wesi, ewsi, nssi, snsi, pesi;
  logic [DW-1:0] wedi, ewdi, nsdi, sndi, pedi;
  logic          weri, ewri, nsri, snri, peri;
  logic          weso, ewso, nsso, snso, peso;
  logic          wero, ewro, nsro, snro, pero;
  logic [DW-1:0] wedo, ewdo, nsdo, sndo, pedo;

  modport master (
    input  wesi, ewsi, nssi, snsi, pesi,
    input  wedi, ewdi, nsdi, sndi, pedi,
    output weri, ewri, nsri, snri, peri,
    output weso, ewso, nsso, snso, peso,
    input  wero, ewro, nsro, snro, pero,
    output wedo, ewdo, nsdo, sndo, pedo
  );

  modport slave (
    output wesi, ewsi, nssi, snsi, pesi,
    output wedi, ewdi, nsdi, sndi, pedi,
    input  weri, ewri, nsri, snri, peri,
    input  weso, ewso, nsso, snso, peso,
    output wero, ewro, nsro, snro, pero,
    input  wedo, ewdo, nsdo, sndo, pedo
  );
endinterface

// File: rtl/mesh_router.sv
// mesh_router: one tile of a 2-D mesh NoC. Five ports (east, west, north,
// south, local PE), single-flit packets, dimension-order (X then Y) routing
// driven by hop counts carried in the header. Two virtual channels share
// the links under an even/odd polarity that toggles every cycle.
//
// Ports:
//   clk      : single clock, all state on the rising edge
//   reset    : synchronous, active-low
//   polarity : current phase p (0 = even, 1 = odd)
//   link     : mesh_router_if.master, five links (we, ew, ns, sn, pe)
//
// Flit header: [63] vc, [62] dx (0 east / 1 west), [61] dy (0 north /
// 1 south), [60:56] reserved, [55:52] hop_x, [51:48] hop_y,
// [47:32] source address, [31:0] payload.
//
// Handshake (every link, phase p = polarity):
//   Inbound : Xri = 1 while the VC-p input buffer is empty. A flit is
//             captured on the rising edge where Xsi & Xri. Senders only
//             present flits whose vc bit equals p.
//   Outbound: Xso = (VC-p output buffer valid) & Xro; Xdo carries that flit
//             while Xso = 1 and is 0 otherwise. The transfer completes on
//             the rising edge where Xso = 1 and the buffer is emptied.
//   Internal: in phase p, VC ~p input buffers move into VC ~p output
//             buffers, so the link side and the crossbar side of any one
//             buffer are never active in the same cycle.
module mesh_router #(
  parameter int DW = 64
) (
  input  logic           clk,
  input  logic           reset,
  output logic           polarity,
  mesh_router_if.master  link
);

  localparam int NP = 5;

  // Port indices: also the round-robin scan order.
  localparam logic [2:0] P_WE = 3'd0;
  localparam logic [2:0] P_EW = 3'd1;
  localparam logic [2:0] P_NS = 3'd2;
  localparam logic [2:0] P_SN = 3'd3;
  localparam logic [2:0] P_PE = 3'd4;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic          r_polarity;
  logic          r_run;                  // 0 during and one cycle after reset
  logic [1:0]    r_in_vld  [NP];         // [port][vc]
  logic [DW-1:0] r_in_dat  [NP][2];
  logic [1:0]    r_out_vld [NP];
  logic [DW-1:0] r_out_dat [NP][2];
  logic [2:0]    r_rr_ptr  [NP][2];      // [output port][vc] next-first input

  // ---------------------------------------------------------------------
  // Link-side wires, packed into per-port arrays
  // ---------------------------------------------------------------------
  logic          w_p;                    // link phase
  logic          w_q;                    // crossbar phase (opposite VC)
  logic [NP-1:0] w_si;
  logic [NP-1:0] w_ro;
  logic [NP-1:0] w_ri;
  logic [NP-1:0] w_so;
  logic [DW-1:0] w_di [NP];
  logic [DW-1:0] w_do [NP];

  // Crossbar wires
  logic [NP-1:0] w_req_vld;
  logic [2:0]    w_req_port [NP];
  logic [DW-1:0] w_req_dat  [NP];
  logic [NP-1:0] w_gnt_vld;
  logic [2:0]    w_gnt_idx  [NP];
  logic [NP-1:0] w_pop;

  assign w_p      = r_polarity;
  assign w_q      = ~r_polarity;
  assign polarity = r_polarity;

  assign w_si = {link.pesi, link.snsi, link.nssi, link.ewsi, link.wesi};
  assign w_ro = {link.pero, link.snro, link.nsro, link.ewro, link.wero};

  assign w_di[P_WE] = link.wedi;
  assign w_di[P_EW] = link.ewdi;
  assign w_di[P_NS] = link.nsdi;
  assign w_di[P_SN] = link.sndi;
  assign w_di[P_PE] = link.pedi;

  assign link.weri = w_ri[P_WE];
  assign link.ewri = w_ri[P_EW];
  assign link.nsri = w_ri[P_NS];
  assign link.snri = w_ri[P_SN];
  assign link.peri = w_ri[P_PE];

  assign link.weso = w_so[P_WE];
  assign link.ewso = w_so[P_EW];
  assign link.nsso = w_so[P_NS];
  assign link.snso = w_so[P_SN];
  assign link.peso = w_so[P_PE];

  assign link.wedo = w_do[P_WE];
  assign link.ewdo = w_do[P_EW];
  assign link.nsdo = w_do[P_NS];
  assign link.sndo = w_do[P_SN];
  assign link.pedo = w_do[P_PE];

  // ---------------------------------------------------------------------
  // Routing helpers
  // ---------------------------------------------------------------------
  // X first, then Y, then eject to the local PE.
  function automatic logic [2:0] route_port(input logic       dx,
                                            input logic       dy,
                                            input logic [3:0] hop_x,
                                            input logic [3:0] hop_y);
    logic [2:0] v_port;
    if (hop_x != 4'd0)      v_port = dx ? P_EW : P_WE;
    else if (hop_y != 4'd0) v_port = dy ? P_SN : P_NS;
    else                    v_port = P_PE;
    return v_port;
  endfunction

  // Decrement the hop count of the dimension being travelled; every other
  // field, including vc, passes through untouched.
  function automatic logic [DW-1:0] route_flit(input logic [DW-1:0] f);
    logic [DW-1:0] v_f;
    v_f = f;
    if (f[55:52] != 4'd0)      v_f[55:52] = f[55:52] - 4'd1;
    else if (f[51:48] != 4'd0) v_f[51:48] = f[51:48] - 4'd1;
    return v_f;
  endfunction

  // ---------------------------------------------------------------------
  // Link side (VC p)
  // ---------------------------------------------------------------------
  always_comb begin
    w_ri = '0;
    w_so = '0;
    for (int i = 0; i < NP; i++) begin
      w_ri[i] = r_run & ~r_in_vld[i][w_p];
      w_so[i] = r_out_vld[i][w_p] & w_ro[i];
      w_do[i] = (r_out_vld[i][w_p] & w_ro[i]) ? r_out_dat[i][w_p] : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Crossbar side (VC ~p): route every occupied input buffer
  // ---------------------------------------------------------------------
  always_comb begin
    w_req_vld = '0;
    for (int i = 0; i < NP; i++) begin
      w_req_vld[i]  = r_in_vld[i][w_q];
      w_req_port[i] = route_port(r_in_dat[i][w_q][62], r_in_dat[i][w_q][61],
                                 r_in_dat[i][w_q][55:52], r_in_dat[i][w_q][51:48]);
      w_req_dat[i]  = route_flit(r_in_dat[i][w_q]);
    end
  end

  // Round-robin per output: scan inputs starting at the pointer, first
  // requester wins. An output whose VC ~p buffer is still full grants
  // nobody, so the requesting input simply holds its flit.
  always_comb begin
    logic [3:0] v_sum;
    logic [2:0] v_idx;
    logic [2:0] v_win;
    logic       v_found;
    v_sum     = '0;
    v_idx     = '0;
    v_win     = '0;
    v_found   = 1'b0;
    w_gnt_vld = '0;
    w_pop     = '0;
    for (int o = 0; o < NP; o++) begin
      v_found = 1'b0;
      v_win   = 3'd0;
      for (int k = 0; k < NP; k++) begin
        v_sum = {1'b0, r_rr_ptr[o][w_q]} + 4'(k);
        if (v_sum >= 4'(NP)) v_sum = v_sum - 4'(NP);
        v_idx = v_sum[2:0];
        if (!v_found && !r_out_vld[o][w_q] && w_req_vld[v_idx] &&
            (w_req_port[v_idx] == 3'(o))) begin
          v_found = 1'b1;
          v_win   = v_idx;
        end
      end
      w_gnt_vld[o] = v_found;
      w_gnt_idx[o] = v_win;
      // Each input targets exactly one output, so at most one grant per input.
      if (v_found) w_pop[v_win] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_polarity <= 1'b0;
      r_run      <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        r_in_vld[i]  <= 2'b00;
        r_out_vld[i] <= 2'b00;
        for (int v = 0; v < 2; v++) begin
          r_in_dat[i][v]  <= '0;
          r_out_dat[i][v] <= '0;
          r_rr_ptr[i][v]  <= 3'd0;
        end
      end
    end else begin
      r_polarity <= ~r_polarity;
      r_run      <= 1'b1;
      for (int i = 0; i < NP; i++) begin
        // Link side, VC p
        if (w_si[i] && w_ri[i]) begin
          r_in_vld[i][w_p] <= 1'b1;
          r_in_dat[i][w_p] <= w_di[i];
        end
        if (w_so[i]) begin
          r_out_vld[i][w_p] <= 1'b0;
        end
        // Crossbar side, VC ~p
        if (w_pop[i]) begin
          r_in_vld[i][w_q] <= 1'b0;
        end
        if (w_gnt_vld[i]) begin
          r_out_vld[i][w_q] <= 1'b1;
          r_out_dat[i][w_q] <= w_req_dat[w_gnt_idx[i]];
          r_rr_ptr[i][w_q]  <= (w_gnt_idx[i] == 3'd4) ? 3'd0 : w_gnt_idx[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_router.sv
// tb_mesh_router: directed bench for mesh_router with a per-output-port
// scoreboard. Port index: 0 = we (east), 1 = ew (west), 2 = ns (north),
// 3 = sn (south), 4 = pe (local).
module tb_mesh_router;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic polarity;

  mesh_router_if #(.DW(64)) bus ();

  mesh_router #(.DW(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .link     (bus)
  );

  logic [4:0]  t_si;
  logic [4:0]  t_ro;
  logic [4:0]  t_ri;
  logic [4:0]  t_so;
  logic [63:0] t_di [5];
  logic [63:0] t_do [5];

  assign bus.wesi = t_si[0];
  assign bus.ewsi = t_si[1];
  assign bus.nssi = t_si[2];
  assign bus.snsi = t_si[3];
  assign bus.pesi = t_si[4];
  assign bus.wedi = t_di[0];
  assign bus.ewdi = t_di[1];
  assign bus.nsdi = t_di[2];
  assign bus.sndi = t_di[3];
  assign bus.pedi = t_di[4];
  assign bus.wero = t_ro[0];
  assign bus.ewro = t_ro[1];
  assign bus.nsro = t_ro[2];
  assign bus.snro = t_ro[3];
  assign bus.pero = t_ro[4];
  assign t_ri = {bus.peri, bus.snri, bus.nsri, bus.ewri, bus.weri};
  assign t_so = {bus.peso, bus.snso, bus.nsso, bus.ewso, bus.weso};
  assign t_do[0] = bus.wedo;
  assign t_do[1] = bus.ewdo;
  assign t_do[2] = bus.nsdo;
  assign t_do[3] = bus.sndo;
  assign t_do[4] = bus.pedo;

  // -------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q [5][$];
  logic [63:0] mon_exp;

  function automatic logic [63:0] mk(input logic vc, input logic dx, input logic dy,
                                     input logic [3:0] hx, input logic [3:0] hy,
                                     input logic [31:0] pl);
    return {vc, dx, dy, 5'b00000, hx, hy, 8'h12, 8'h34, pl};
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int o = 0; o < 5; o++) n += exp_q[o].size();
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic ph);
    int n;
    n = 0;
    while (polarity !== ph && n < 10) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 10) else begin
      errors++;
      $error("FAIL wait_phase observed=%b expected=%b", polarity, ph);
    end
  endtask

  // Present one flit on a port in the phase matching its vc bit.
  task automatic send(input int port, input logic [63:0] flit);
    int n;
    logic ph;
    ph = flit[63];
    n  = 0;
    tick();
    while (!(polarity === ph && t_ri[port] === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout port=%0d observed_ri=%b expected_ri=1", port, t_ri[port]);
    end else begin
      t_si[port] = 1'b1;
      t_di[port] = flit;
      tick();
      t_si[port] = 1'b0;
      t_di[port] = '0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (pending() != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    assert (pending() == 0) else begin
      errors++;
      $error("FAIL %s_drain observed=%0d_pending expected=0", tag, pending());
    end
  endtask

  // -------------------------------------------------------------------
  // Output monitor
  // -------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int o = 0; o < 5; o++) begin
        if (t_so[o]) begin
          checks++;
          assert (exp_q[o].size() != 0) else begin
            errors++;
            $error("FAIL out_unexpected port=%0d observed=%h expected=none", o, t_do[o]);
          end
          if (exp_q[o].size() != 0) begin
            mon_exp = exp_q[o].pop_front();
            checks++;
            assert (t_do[o] === mon_exp) else begin
              errors++;
              $error("FAIL out_data port=%0d observed=%h expected=%h", o, t_do[o], mon_exp);
            end
          end
        end else begin
          checks++;
          assert (t_do[o] === 64'h0) else begin
            errors++;
            $error("FAIL out_idle_zero port=%0d observed=%h expected=0", o, t_do[o]);
          end
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------
  initial begin
    logic [31:0] pl;
    logic [63:0] fa, fb, fc;

    reset = 1'b0;
    t_si  = '0;
    t_ro  = '1;
    for (int i = 0; i < 5; i++) t_di[i] = '0;

    // 1. Reset, then release: polarity toggles, ri follows the phase
    repeat (2) @(posedge clk);
    #1;
    chk("rst_polarity", 64'(polarity), 64'd0);
    chk("rst_so", 64'(t_so), 64'd0);
    chk("rst_ri", 64'(t_ri), 64'd0);
    reset = 1'b1;
    tick();
    chk("run_polarity1", 64'(polarity), 64'd1);
    chk("run_ri1", 64'(t_ri), 64'h1f);
    chk("run_so1", 64'(t_so), 64'd0);
    tick();
    chk("run_polarity0", 64'(polarity), 64'd0);
    chk("run_ri0", 64'(t_ri), 64'h1f);

    // 2. PE inject east one hop; appears two cycles after capture
    pl = $urandom;
    exp_q[0].push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, pl));
    send(4, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, pl));
    @(posedge clk);
    @(negedge clk);
    chk("t2_weso_latency", 64'(t_so[0]), 64'd1);
    wait_drain("t2");

    // 3. Eject on west input; PE backpressure holds and blocks ewri
    t_ro[4] = 1'b0;
    fa = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom);
    fb = mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, $urandom);
    exp_q[4].push_back(fa);
    exp_q[4].push_back(fb);
    send(1, fa);
    repeat (4) tick();
    chk("t3_peso_held", 64'(t_so[4]), 64'd0);
    send(1, fb);
    tick();
    chk("t3_phase1", 64'(polarity), 64'd1);
    chk("t3_ewri_blocked", 64'(t_ri[1]), 64'd0);
    t_ro[4] = 1'b1;
    wait_drain("t3");

    // 4. Y routing and multi-hop west from the PE
    pl = $urandom;
    exp_q[2].push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, pl));
    send(4, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, pl));
    pl = $urandom;
    exp_q[3].push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, pl));
    send(4, mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, pl));
    pl = $urandom;
    exp_q[1].push_back(mk(1'b0, 1'b1, 1'b0, 4'd2, 4'd2, pl));
    send(4, mk(1'b0, 1'b1, 1'b0, 4'd3, 4'd2, pl));
    wait_drain("t4");

    // 5a. E, W, S all eject on VC0 in the same cycle; pointer starts at 0
    fa = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'(32'hA000_0000 + $urandom_range(0, 4095)));
    fb = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'(32'hB000_0000 + $urandom_range(0, 4095)));
    fc = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'(32'hC000_0000 + $urandom_range(0, 4095)));
    exp_q[4].push_back(fa);
    exp_q[4].push_back(fb);
    exp_q[4].push_back(fc);
    tick();
    wait_phase(1'b0);
    chk("t5a_ready", 64'(t_ri & 5'b01011), 64'h0b);
    t_si[0] = 1'b1; t_di[0] = fa;
    t_si[1] = 1'b1; t_di[1] = fb;
    t_si[3] = 1'b1; t_di[3] = fc;
    tick();
    t_si = '0;
    for (int i = 0; i < 5; i++) t_di[i] = '0;
    wait_drain("t5a");

    // 5b. Same on VC1; that pointer sits past the west input from step 3
    fa = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom);
    fb = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom);
    fc = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom);
    exp_q[4].push_back(fc);
    exp_q[4].push_back(fa);
    exp_q[4].push_back(fb);
    tick();
    wait_phase(1'b1);
    chk("t5b_ready", 64'(t_ri & 5'b01011), 64'h0b);
    t_si[0] = 1'b1; t_di[0] = fa;
    t_si[1] = 1'b1; t_di[1] = fb;
    t_si[3] = 1'b1; t_di[3] = fc;
    tick();
    t_si = '0;
    for (int i = 0; i < 5; i++) t_di[i] = '0;
    wait_drain("t5b");

    // 6. Fill buffers under backpressure, then reset mid-flight
    t_ro = '0;
    send(4, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, $urandom));
    send(1, mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, $urandom));
    send(2, mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, $urandom));
    send(3, mk(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, $urandom));
    send(0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, $urandom));
    repeat (3) tick();
    reset = 1'b0;
    tick();
    t_ro = '1;
    #1;
    chk("t6_rst_so", 64'(t_so), 64'd0);
    chk("t6_rst_ri", 64'(t_ri), 64'd0);
    chk("t6_rst_polarity", 64'(polarity), 64'd0);
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    reset = 1'b1;
    repeat (20) tick();
    pl = $urandom;
    exp_q[4].push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, pl));
    send(4, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, pl));
    wait_drain("t6");
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
